// File: rtl/sseg_mux_driver_if.sv
// Bus between a datapath and the multiplexed seven-segment driver.
// master = datapath side, slave = display driver.
interface sseg_mux_driver_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [NUM_DIGITS-1:0]     blank_in;
  logic                      lz_suppress;
  logic [6:0]                seg;
  logic                      dp;
  logic [NUM_DIGITS-1:0]     an;
  logic                      frame_done;

  modport master (
    output load, value, dp_in, blank_in, lz_suppress,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  load, value, dp_in, blank_in, lz_suppress,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/sseg_mux_driver.sv
// Time-multiplexed N-digit seven-segment driver with a double-buffered display
// word, leading-zero suppression and per-digit blanking.
module sseg_mux_driver #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  sseg_mux_driver_if.slave bus
);
  localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;

  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF   = ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = ACTIVE_LOW ? '1 : '0;

  logic [DIV_W-1:0]      div_cnt;
  logic [IDX_W-1:0]      digit_idx;
  logic                  tick;
  logic                  wrap;

  logic [VAL_W-1:0]      pend_val;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [NUM_DIGITS-1:0] pend_blank;
  logic                  dirty;
  logic [VAL_W-1:0]      act_val;
  logic [NUM_DIGITS-1:0] act_dp;
  logic [NUM_DIGITS-1:0] act_blank;

  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_dark;
  logic                  zero_run;
  int unsigned           k;

  logic [6:0]            seg_al;
  logic                  dp_on;
  logic [NUM_DIGITS-1:0] an_on;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;

  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  frame_done_q;

  // Active-low gfedcba patterns.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_to_seg = 7'h40;
      4'h1:    hex_to_seg = 7'h79;
      4'h2:    hex_to_seg = 7'h24;
      4'h3:    hex_to_seg = 7'h30;
      4'h4:    hex_to_seg = 7'h19;
      4'h5:    hex_to_seg = 7'h12;
      4'h6:    hex_to_seg = 7'h02;
      4'h7:    hex_to_seg = 7'h78;
      4'h8:    hex_to_seg = 7'h00;
      4'h9:    hex_to_seg = 7'h10;
      4'hA:    hex_to_seg = 7'h08;
      4'hB:    hex_to_seg = 7'h03;
      4'hC:    hex_to_seg = 7'h46;
      4'hD:    hex_to_seg = 7'h21;
      4'hE:    hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  assign tick = (div_cnt == DIV_LAST);
  assign wrap = tick && (digit_idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt      <= '0;
      digit_idx    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt      <= tick ? '0 : div_cnt + 1'b1;
      frame_done_q <= wrap;
      if (tick) begin
        digit_idx <= wrap ? '0 : digit_idx + 1'b1;
      end
    end
  end

  // The wrap-cycle transfer reads pending before a same-cycle load lands in it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      dirty      <= 1'b0;
      act_val    <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
    end else begin
      if (wrap && dirty) begin
        act_val   <= pend_val;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
      end
      if (bus.load) begin
        pend_val   <= bus.value;
        pend_dp    <= bus.dp_in;
        pend_blank <= bus.blank_in;
        dirty      <= 1'b1;
      end else if (wrap) begin
        dirty <= 1'b0;
      end
    end
  end

  // Walk from the most significant digit so zero_run covers digits k..N-1.
  always_comb begin
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_dark = 1'b0;
    zero_run = 1'b1;
    k        = 0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      k        = NUM_DIGITS - 1 - i;
      zero_run = zero_run && (act_val[4*k +: 4] == 4'h0);
      if (digit_idx == IDX_W'(k)) begin
        cur_nib  = act_val[4*k +: 4];
        cur_dp   = act_dp[k];
        cur_dark = act_blank[k] || (bus.lz_suppress && (k != 0) && zero_run);
      end
    end
  end

  always_comb begin
    seg_al  = cur_dark ? 7'h7F : hex_to_seg(cur_nib);
    dp_on   = cur_dp && !cur_dark;
    an_on   = NUM_DIGITS'(1) << digit_idx;
    seg_nxt = ACTIVE_LOW ? seg_al : ~seg_al;
    dp_nxt  = ACTIVE_LOW ? ~dp_on : dp_on;
    an_nxt  = ACTIVE_LOW ? ~an_on : an_on;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q <= SEG_OFF;
      dp_q  <= DP_OFF;
      an_q  <= AN_OFF;
    end else begin
      seg_q <= seg_nxt;
      dp_q  <= dp_nxt;
      an_q  <= an_nxt;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_sseg_mux_driver.sv
// Bench for sseg_mux_driver: an active-low and an active-high instance share
// stimulus; per-slot expectations are queued per frame and checked each clock.
module tb_sseg_mux_driver;
  localparam int unsigned ND = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sseg_mux_driver_if #(.NUM_DIGITS(ND)) bus0 ();
  sseg_mux_driver_if #(.NUM_DIGITS(ND)) bus1 ();

  assign bus1.load        = bus0.load;
  assign bus1.value       = bus0.value;
  assign bus1.dp_in       = bus0.dp_in;
  assign bus1.blank_in    = bus0.blank_in;
  assign bus1.lz_suppress = bus0.lz_suppress;

  sseg_mux_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  sseg_mux_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(4), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Expected active-low outputs for slot s (0..15) of a 4-clock-per-digit frame.
  function automatic exp_t exp_slot(input int s, input logic [15:0] v, input logic [3:0] dpv,
                                    input logic [3:0] blk, input logic lz);
    int          d;
    logic [15:0] t;
    logic        dark;
    exp_t        e;
    d     = s / 4;
    t     = v >> (4 * d);
    dark  = blk[d] || (lz && (d > 0) && (t == 16'h0));
    e.an  = ~(4'b0001 << d);
    e.seg = dark ? 7'h7F : seg_tab[t[3:0]];
    e.dp  = !(dpv[d] && !dark);
    e.fd  = (s == 15);
    return e;
  endfunction

  task automatic push_frame(input logic [15:0] v, input logic [3:0] dpv,
                            input logic [3:0] blk, input logic lz);
    for (int s = 0; s < 16; s++) sb.push_back(exp_slot(s, v, dpv, blk, lz));
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] blk);
    bus0.value    = v;
    bus0.dp_in    = dpv;
    bus0.blank_in = blk;
    bus0.load     = 1'b1;
    @(negedge clk);
    bus0.load     = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_frame();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (bus0.frame_done === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL frame_wait: frame_done not seen, required within 64 clocks");
    end
  endtask

  // Scoreboard: one queued slot per clock, checked just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total += 8;
      if (bus0.an !== e.an) begin
        bad++; $display("FAIL an_lo: got %h required %h", bus0.an, e.an);
      end
      if (bus0.seg !== e.seg) begin
        bad++; $display("FAIL seg_lo: got %h required %h (an %h)", bus0.seg, e.seg, e.an);
      end
      if (bus0.dp !== e.dp) begin
        bad++; $display("FAIL dp_lo: got %b required %b (an %h)", bus0.dp, e.dp, e.an);
      end
      if (bus0.frame_done !== e.fd) begin
        bad++; $display("FAIL fd_lo: got %b required %b", bus0.frame_done, e.fd);
      end
      if (bus1.an !== ~e.an) begin
        bad++; $display("FAIL an_hi: got %h required %h", bus1.an, ~e.an);
      end
      if (bus1.seg !== ~e.seg) begin
        bad++; $display("FAIL seg_hi: got %h required %h", bus1.seg, ~e.seg);
      end
      if (bus1.dp !== ~e.dp) begin
        bad++; $display("FAIL dp_hi: got %b required %b", bus1.dp, ~e.dp);
      end
      if (bus1.frame_done !== e.fd) begin
        bad++; $display("FAIL fd_hi: got %b required %b", bus1.frame_done, e.fd);
      end
    end
  end

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total += 8;
    if (bus0.seg !== 7'h7F)      begin bad++; $display("FAIL rst_seg_lo: got %h required 7f", bus0.seg); end
    if (bus0.an !== 4'hF)        begin bad++; $display("FAIL rst_an_lo: got %h required f", bus0.an); end
    if (bus0.dp !== 1'b1)        begin bad++; $display("FAIL rst_dp_lo: got %b required 1", bus0.dp); end
    if (bus0.frame_done !== 1'b0) begin bad++; $display("FAIL rst_fd_lo: got %b required 0", bus0.frame_done); end
    if (bus1.seg !== 7'h00)      begin bad++; $display("FAIL rst_seg_hi: got %h required 00", bus1.seg); end
    if (bus1.an !== 4'h0)        begin bad++; $display("FAIL rst_an_hi: got %h required 0", bus1.an); end
    if (bus1.dp !== 1'b0)        begin bad++; $display("FAIL rst_dp_hi: got %b required 0", bus1.dp); end
    if (bus1.frame_done !== 1'b0) begin bad++; $display("FAIL rst_fd_hi: got %b required 0", bus1.frame_done); end
    rst_n = 1'b1;
    push_frame(16'h0000, 4'h0, 4'h0, 1'b0);
    repeat (3) @(negedge clk);
    do_load(16'h12AF, 4'h0, 4'h0);
    drain();
  endtask

  task automatic test_decode();
    wait_frame();
    push_frame(16'h12AF, 4'h0, 4'h0, 1'b0);
    repeat (6) @(negedge clk);
    do_load(16'h0000, 4'h0, 4'h0);
    drain();
  endtask

  task automatic test_mid_frame();
    wait_frame();
    push_frame(16'h0000, 4'h0, 4'h0, 1'b0);
    repeat (2) @(negedge clk);
    do_load(16'h0040, 4'h0, 4'h0);
    drain();
  endtask

  task automatic test_lz();
    wait_frame();
    bus0.lz_suppress = 1'b1;
    push_frame(16'h0040, 4'h0, 4'h0, 1'b1);
    repeat (4) @(negedge clk);
    do_load(16'h3210, 4'b0010, 4'b0100);
    drain();
  endtask

  task automatic test_dp_blank();
    wait_frame();
    bus0.lz_suppress = 1'b0;
    push_frame(16'h3210, 4'b0010, 4'b0100, 1'b0);
    drain();
  endtask

  task automatic test_reset_mid();
    repeat (3) @(negedge clk);
    do_load(16'h9ABC, 4'hF, 4'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total += 4;
    if (bus0.seg !== 7'h7F)      begin bad++; $display("FAIL rstmid_seg: got %h required 7f", bus0.seg); end
    if (bus0.an !== 4'hF)        begin bad++; $display("FAIL rstmid_an: got %h required f", bus0.an); end
    if (bus0.dp !== 1'b1)        begin bad++; $display("FAIL rstmid_dp: got %b required 1", bus0.dp); end
    if (bus0.frame_done !== 1'b0) begin bad++; $display("FAIL rstmid_fd: got %b required 0", bus0.frame_done); end
    rst_n = 1'b1;
    push_frame(16'h0000, 4'h0, 4'h0, 1'b0);
    drain();
  endtask

  task automatic test_wrap_load();
    wait_frame();
    push_frame(16'h0000, 4'h0, 4'h0, 1'b0);
    repeat (15) @(negedge clk);
    do_load(16'h4321, 4'h0, 4'h0);
    total++;
    if (bus0.frame_done !== 1'b1) begin
      bad++; $display("FAIL wrap_align: frame_done got %b required 1", bus0.frame_done);
    end
    push_frame(16'h0000, 4'h0, 4'h0, 1'b0);
    drain();
    wait_frame();
    push_frame(16'h4321, 4'h0, 4'h0, 1'b0);
    drain();
  endtask

  initial begin
    rst_n            = 1'b0;
    bus0.load        = 1'b0;
    bus0.value       = '0;
    bus0.dp_in       = '0;
    bus0.blank_in    = '0;
    bus0.lz_suppress = 1'b0;
    test_reset();
    test_decode();
    test_mid_frame();
    test_lz();
    test_dp_blank();
    test_reset_mid();
    test_wrap_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
